lt24_frame_sequencer: RTL and testbench

Full-frame pixel sequencer for the LT24 pixel interface. It accepts frame requests from game logic: either a solid-colour fill or a full-screen image read from a shared image ROM. It walks every pixel in raster order, drives xAddr/yAddr/pixelData/pixelWrite against the display's pixelReady handshake, and generates the shared ROM address. It compensates for ROM read latency and holds one pending request, so game logic can queue the next screen while the current one is drawn.

---
 rtl/lt24_seq_pkg.sv | 21 ++
 rtl/lt24_frame_sequencer_if.sv | 32 +++
 rtl/lt24_xy_walker.sv | 62 ++++++
 rtl/lt24_frame_sequencer.sv | 129 ++++++++++++
 tb/tb_lt24_frame_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lt24_seq_pkg.sv
// Shared types and constants for the LT24 full-frame pixel sequencer.
package lt24_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFetch,
    StWrite,
    StDone
  } state_e;

  localparam logic SRC_FILL = 1'b0;
  localparam logic SRC_ROM  = 1'b1;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] GREEN  = 16'h5FE8;
  localparam logic [15:0] RED    = 16'hFA28;
  localparam logic [15:0] BLUE   = 16'h12DE;
  localparam logic [15:0] YELLOW = 16'hFFC6;

endpackage

// File: rtl/lt24_frame_sequencer_if.sv
// Request, pixel and ROM signals between game logic, the sequencer and the display/ROM.
interface lt24_frame_sequencer_if #(
  parameter int unsigned ROM_ADDR_W = 17
) ();

  logic                  reqValid;
  logic                  reqReady;
  logic                  reqSrc;
  logic [15:0]           reqColour;
  logic                  busy;
  logic                  frameDone;
  logic [7:0]            xAddr;
  logic [8:0]            yAddr;
  logic [15:0]           pixelData;
  logic                  pixelWrite;
  logic                  pixelReady;
  logic [ROM_ADDR_W-1:0] romAddr;
  logic [15:0]           romData;

  // Sequencer side.
  modport master (
    input  reqValid, reqSrc, reqColour, pixelReady, romData,
    output reqReady, busy, frameDone, xAddr, yAddr, pixelData, pixelWrite, romAddr
  );

  // Game logic, display and ROM side.
  modport slave (
    output reqValid, reqSrc, reqColour, pixelReady, romData,
    input  reqReady, busy, frameDone, xAddr, yAddr, pixelData, pixelWrite, romAddr
  );

endinterface

// File: rtl/lt24_xy_walker.sv
// Raster-order x/y counters with a linear address kept in step, so no multiplier is needed.
module lt24_xy_walker #(
  parameter int unsigned WIDTH      = 240,
  parameter int unsigned HEIGHT     = 320,
  parameter int unsigned ROM_ADDR_W = 17
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  step_i,
  output logic [7:0]            x_o,
  output logic [8:0]            y_o,
  output logic [ROM_ADDR_W-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [7:0] XMax = 8'(WIDTH - 1);
  localparam logic [8:0] YMax = 9'(HEIGHT - 1);

  logic [7:0]            x_q, x_d;
  logic [8:0]            y_q, y_d;
  logic [ROM_ADDR_W-1:0] addr_q, addr_d;

  assign last_o = (x_q == XMax) && (y_q == YMax);

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (step_i) begin
      // Stepping past the final pixel wraps everything back to the origin.
      if (x_q == XMax) begin
        x_d = '0;
        y_d = (y_q == YMax) ? 9'd0 : y_q + 9'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
      addr_d = last_o ? '0 : addr_q + ROM_ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/lt24_frame_sequencer.sv
// Full-frame LT24 pixel sequencer: solid fill or ROM image, with a single-entry request queue.
module lt24_frame_sequencer
  import lt24_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 240,
  parameter int unsigned HEIGHT      = 320,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned ROM_ADDR_W  = 17
) (
  input  logic                   clock,
  input  logic                   n_reset,
  lt24_frame_sequencer_if.master bus
);

  localparam logic [7:0] LatLast = 8'(ROM_LATENCY - 1);

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_src_q, pend_src_d;
  logic [15:0] pend_colour_q, pend_colour_d;
  logic        act_src_q, act_src_d;
  logic [15:0] pixel_data_q, pixel_data_d;
  logic [7:0]  lat_cnt_q, lat_cnt_d;

  logic walk_clear;
  logic walk_step;
  logic walk_last;

  lt24_xy_walker #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .ROM_ADDR_W(ROM_ADDR_W)
  ) u_walker (
    .clk_i  (clock),
    .rst_ni (n_reset),
    .clear_i(walk_clear),
    .step_i (walk_step),
    .x_o    (bus.xAddr),
    .y_o    (bus.yAddr),
    .addr_o (bus.romAddr),
    .last_o (walk_last)
  );

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_src_d    = pend_src_q;
    pend_colour_d = pend_colour_q;
    act_src_d     = act_src_q;
    pixel_data_d  = pixel_data_q;
    lat_cnt_d     = lat_cnt_q;
    walk_clear    = 1'b0;
    walk_step     = 1'b0;

    // The slot is full throughout LOAD, so a fill and a clear never coincide.
    if (bus.reqValid && !pend_valid_q) begin
      pend_valid_d  = 1'b1;
      pend_src_d    = bus.reqSrc;
      pend_colour_d = bus.reqColour;
    end

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) state_d = StLoad;
      end
      StLoad: begin
        pend_valid_d = 1'b0;
        act_src_d    = pend_src_q;
        lat_cnt_d    = '0;
        walk_clear   = 1'b1;
        if (pend_src_q == SRC_FILL) begin
          pixel_data_d = pend_colour_q;
          state_d      = StWrite;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (lat_cnt_q == LatLast) begin
          pixel_data_d = bus.romData;
          lat_cnt_d    = '0;
          state_d      = StWrite;
        end else begin
          lat_cnt_d = lat_cnt_q + 8'd1;
        end
      end
      StWrite: begin
        if (bus.pixelReady) begin
          walk_step = 1'b1;
          if (walk_last)                 state_d = StDone;
          else if (act_src_q == SRC_ROM) state_d = StFetch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q       <= StIdle;
      pend_valid_q  <= 1'b0;
      pend_src_q    <= SRC_FILL;
      pend_colour_q <= BLACK;
      act_src_q     <= SRC_FILL;
      pixel_data_q  <= BLACK;
      lat_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_src_q    <= pend_src_d;
      pend_colour_q <= pend_colour_d;
      act_src_q     <= act_src_d;
      pixel_data_q  <= pixel_data_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

  assign bus.reqReady   = !pend_valid_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frameDone  = (state_q == StDone);
  assign bus.pixelWrite = (state_q == StWrite);
  assign bus.pixelData  = pixel_data_q;

endmodule

// File: tb/tb_lt24_frame_sequencer.sv
// Directed bench: three sequencer instances (240x8 L=1, 4x3 L=1, 4x3 L=2) behind one output mux.
module tb_lt24_frame_sequencer;
  import lt24_seq_pkg::*;

  typedef struct {
    int          dut;
    logic        src;
    logic [15:0] colour;
    int          rnd_ready;
    int          w;
    int          h;
    int          lat;
    int          exp_pix;
    int          exp_first_k;
    int          exp_last_x;
    int          exp_last_y;
    logic [15:0] exp_last_data;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        n_reset;
  logic        req_valid;
  logic        req_src;
  logic [15:0] req_colour;
  logic        pixel_ready;
  int          sel;
  int          n_tests;
  int          n_fail;

  lt24_frame_sequencer_if #(.ROM_ADDR_W(17)) bus_a ();
  lt24_frame_sequencer_if #(.ROM_ADDR_W(17)) bus_b ();
  lt24_frame_sequencer_if #(.ROM_ADDR_W(17)) bus_c ();

  lt24_frame_sequencer #(.WIDTH(240), .HEIGHT(8), .ROM_LATENCY(1), .ROM_ADDR_W(17)) u_dut_a (
    .clock(clock), .n_reset(n_reset), .bus(bus_a));
  lt24_frame_sequencer #(.WIDTH(4), .HEIGHT(3), .ROM_LATENCY(1), .ROM_ADDR_W(17)) u_dut_b (
    .clock(clock), .n_reset(n_reset), .bus(bus_b));
  lt24_frame_sequencer #(.WIDTH(4), .HEIGHT(3), .ROM_LATENCY(2), .ROM_ADDR_W(17)) u_dut_c (
    .clock(clock), .n_reset(n_reset), .bus(bus_c));

  assign bus_a.reqValid = req_valid && (sel == 0);
  assign bus_b.reqValid = req_valid && (sel == 1);
  assign bus_c.reqValid = req_valid && (sel == 2);
  assign bus_a.reqSrc = req_src;
  assign bus_b.reqSrc = req_src;
  assign bus_c.reqSrc = req_src;
  assign bus_a.reqColour = req_colour;
  assign bus_b.reqColour = req_colour;
  assign bus_c.reqColour = req_colour;
  assign bus_a.pixelReady = pixel_ready;
  assign bus_b.pixelReady = pixel_ready;
  assign bus_c.pixelReady = pixel_ready;

  // ROM models: data = address; latency 1 is combinational, latency 2 adds one register.
  logic [16:0] rom_c_q;
  always @(posedge clock) rom_c_q <= bus_c.romAddr;
  assign bus_a.romData = bus_a.romAddr[15:0];
  assign bus_b.romData = bus_b.romAddr[15:0];
  assign bus_c.romData = rom_c_q[15:0];

  logic        m_req_ready, m_busy, m_done, m_write;
  logic [7:0]  m_x;
  logic [8:0]  m_y;
  logic [15:0] m_data;
  logic [16:0] m_addr;

  always_comb begin
    m_req_ready = bus_c.reqReady;
    m_busy      = bus_c.busy;
    m_done      = bus_c.frameDone;
    m_write     = bus_c.pixelWrite;
    m_x         = bus_c.xAddr;
    m_y         = bus_c.yAddr;
    m_data      = bus_c.pixelData;
    m_addr      = bus_c.romAddr;
    if (sel == 0) begin
      m_req_ready = bus_a.reqReady;
      m_busy      = bus_a.busy;
      m_done      = bus_a.frameDone;
      m_write     = bus_a.pixelWrite;
      m_x         = bus_a.xAddr;
      m_y         = bus_a.yAddr;
      m_data      = bus_a.pixelData;
      m_addr      = bus_a.romAddr;
    end else if (sel == 1) begin
      m_req_ready = bus_b.reqReady;
      m_busy      = bus_b.busy;
      m_done      = bus_b.frameDone;
      m_write     = bus_b.pixelWrite;
      m_x         = bus_b.xAddr;
      m_y         = bus_b.yAddr;
      m_data      = bus_b.pixelData;
      m_addr      = bus_b.romAddr;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int hs = 0, done_cnt = 0, done_k = -1, first_w = -1, last_hs_k = -1, wcyc = 0;
    int ex = 0, ey = 0, lx = -1, ly = -1;
    logic [15:0] ld = '0, ed, pd = '0;
    logic [7:0]  px = '0;
    logic [8:0]  py = '0;
    logic        prev_hold = 1'b0;
    sel         = v.dut;
    req_src     = v.src;
    req_colour  = v.colour;
    pixel_ready = 1'b1;
    @(negedge clock);
    chk("idle_req_ready", m_req_ready, 1);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    chk("accepted_req_ready", m_req_ready, 0);
    for (int k = 0; k < 8 * v.w * v.h + 50; k++) begin
      if (k > 0) @(negedge clock);
      if (prev_hold) begin
        chk("hold_write", m_write, 1);
        chk("hold_x", m_x, px);
        chk("hold_y", m_y, py);
        chk("hold_data", m_data, pd);
      end
      pixel_ready = (v.rnd_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_hold   = m_write && !pixel_ready;
      px = m_x;
      py = m_y;
      pd = m_data;
      if (m_write) begin
        wcyc++;
        if (first_w < 0) first_w = k;
      end
      if (m_write && pixel_ready) begin
        ed = (v.src == SRC_ROM) ? 16'(ey * v.w + ex) : v.colour;
        chk("pix_x", m_x, ex);
        chk("pix_y", m_y, ey);
        chk("pix_data", m_data, ed);
        chk("rom_addr", m_addr, ey * v.w + ex);
        lx = m_x;
        ly = m_y;
        ld = m_data;
        hs++;
        last_hs_k = k;
        if (ex == v.w - 1) begin
          ex = 0;
          ey++;
        end else begin
          ex++;
        end
      end
      if (m_done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          chk("done_after_last", k, last_hs_k + 1);
        end
      end
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    pixel_ready = 1'b1;
    chk("frame_done_count", done_cnt, 1);
    chk("pixel_count", hs, v.exp_pix);
    chk("last_x", lx, v.exp_last_x);
    chk("last_y", ly, v.exp_last_y);
    chk("last_data", ld, v.exp_last_data);
    chk("first_write_cycle", first_w, v.exp_first_k);
    if (v.rnd_ready == 0) begin
      chk("write_cycles", wcyc, v.exp_pix);
      chk("write_span", last_hs_k - first_w + 1,
          (v.src == SRC_ROM) ? (v.lat + 1) * v.exp_pix - v.lat : v.exp_pix);
    end
  endtask

  vec_t vecs[6];
  vec_t post_rst_vec;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int done_seen;
    vecs[0] = '{0, SRC_FILL, RED,    0, 240, 8, 1, 1920, 2, 239, 7, RED};
    vecs[1] = '{0, SRC_ROM,  BLACK,  0, 240, 8, 1, 1920, 3, 239, 7, 16'h077F};
    vecs[2] = '{1, SRC_FILL, GREEN,  1, 4,   3, 1, 12,   2, 3,   2, GREEN};
    vecs[3] = '{1, SRC_ROM,  BLACK,  1, 4,   3, 1, 12,   3, 3,   2, 16'h000B};
    vecs[4] = '{2, SRC_ROM,  BLACK,  0, 4,   3, 2, 12,   4, 3,   2, 16'h000B};
    vecs[5] = '{2, SRC_FILL, BLUE,   0, 4,   3, 2, 12,   2, 3,   2, BLUE};
    post_rst_vec = '{0, SRC_FILL, YELLOW, 0, 240, 8, 1, 1920, 2, 239, 7, YELLOW};

    n_tests = 0;
    n_fail = 0;
    n_reset = 1'b0;
    req_valid = 1'b0;
    req_src = SRC_FILL;
    req_colour = BLACK;
    pixel_ready = 1'b1;
    sel = 0;
    repeat (3) @(negedge clock);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_x", m_x, 0);
      chk("rst_y", m_y, 0);
      chk("rst_data", m_data, 0);
      chk("rst_write", m_write, 0);
      chk("rst_addr", m_addr, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_req_ready", m_req_ready, 1);
    end
    @(negedge clock);
    n_reset = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Queue while busy: one accept, later strobes refused, queued frame 3 cycles after DONE.
    sel = 1;
    req_src = SRC_FILL;
    req_colour = YELLOW;
    pixel_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("b2b_busy", m_busy, 1);
    chk("b2b_write_stalled", m_write, 1);
    chk("b2b_slot_free", m_req_ready, 1);
    req_colour = GREEN;
    req_valid = 1'b1;
    @(negedge clock);
    req_colour = BLUE;
    chk("b2b_refused_1", m_req_ready, 0);
    @(negedge clock);
    chk("b2b_refused_2", m_req_ready, 0);
    @(negedge clock);
    req_valid = 1'b0;
    chk("b2b_first_x_held", m_x, 0);
    pixel_ready = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 100 && done_seen == 0; k++) begin
      @(negedge clock);
      if (m_done) done_seen = 1;
    end
    chk("b2b_frame1_done", done_seen, 1);
    @(negedge clock);
    chk("b2b_gap_idle_busy", m_busy, 0);
    chk("b2b_gap_idle_write", m_write, 0);
    @(negedge clock);
    chk("b2b_gap_load_busy", m_busy, 1);
    chk("b2b_gap_load_slot", m_req_ready, 0);
    @(negedge clock);
    chk("b2b_q_write", m_write, 1);
    chk("b2b_q_x", m_x, 0);
    chk("b2b_q_y", m_y, 0);
    chk("b2b_q_data", m_data, GREEN);
    chk("b2b_q_slot_free", m_req_ready, 1);
    hs = 0;
    done_seen = 0;
    for (int k = 0; k < 100 && done_seen == 0; k++) begin
      if (m_write && pixel_ready) begin
        chk("b2b_q_pix_data", m_data, GREEN);
        hs++;
      end
      @(negedge clock);
      if (m_done) done_seen = 1;
    end
    chk("b2b_q_done", done_seen, 1);
    chk("b2b_q_pixels", hs, 12);
    chk("b2b_no_extra_req", m_req_ready, 1);

    // Reset while pixel 100 of a ROM frame is on the bus.
    sel = 0;
    req_src = SRC_ROM;
    @(negedge clock);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    hs = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (m_write) begin
        if (hs == 100) begin
          chk("mid_rst_pixel_x", m_x, 100);
          n_reset = 1'b0;
          break;
        end
        hs++;
      end
    end
    chk("mid_rst_reached", hs, 100);
    @(negedge clock);
    chk("mid_rst_write", m_write, 0);
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_x", m_x, 0);
    chk("mid_rst_y", m_y, 0);
    chk("mid_rst_addr", m_addr, 0);
    chk("mid_rst_req_ready", m_req_ready, 1);
    chk("mid_rst_done", m_done, 0);
    @(negedge clock);
    n_reset = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (m_done || m_busy) done_seen = 1;
    end
    chk("post_rst_quiet", done_seen, 0);
    run_frame(post_rst_vec);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
